// File: rtl/cache_pkg.sv
// Shared cache definitions: flush FSM state encoding and index-width helper.
package cache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWb,
        StDone
    } flush_state_e;

    // Index width for n entries; a single entry still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_way_pick.sv
// Lowest-set-bit priority encoder across the ways of one set.
module cache_way_pick
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    localparam int unsigned WAY_W = idx_w(WAYS)
) (
    input  logic [WAYS-1:0]  i_bits,
    output logic [WAY_W-1:0] o_idx,
    output logic             o_any
);

    // Scan downward so the lowest set bit is the last one assigned.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (i_bits[i]) begin
                o_idx = WAY_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_state_array.sv
// Per-line valid/dirty store with combinational lookup, victim pick and a
// sequenced flush that hands dirty lines to write-back before invalidating.
module cache_state_array
    import cache_pkg::*;
#(
    parameter int unsigned SETS = 8,
    parameter int unsigned WAYS = 4,
    localparam int unsigned SET_W = idx_w(SETS),
    localparam int unsigned WAY_W = idx_w(WAYS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [SET_W-1:0] i_rd_set,
    output logic [WAYS-1:0]  o_valid_out,
    output logic [WAYS-1:0]  o_dirty_out,
    output logic [WAY_W-1:0] o_victim_way,
    output logic             o_all_valid,
    input  logic             i_wr_en,
    output logic             o_wr_ready,
    input  logic [SET_W-1:0] i_wr_set,
    input  logic [WAYS-1:0]  i_wr_way_mask,
    input  logic             i_wr_valid,
    input  logic             i_wr_dirty,
    input  logic             i_flush_req,
    output logic             o_flush_busy,
    output logic             o_flush_done,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [SET_W-1:0] o_wb_set,
    output logic [WAY_W-1:0] o_wb_way
);

    logic [SETS-1:0][WAYS-1:0] r_valid;
    logic [SETS-1:0][WAYS-1:0] r_dirty;
    flush_state_e              r_state;
    flush_state_e              w_state_d;
    logic [SET_W-1:0]          r_set;
    logic [SET_W-1:0]          r_wb_set;
    logic [WAY_W-1:0]          r_wb_way;
    logic [WAY_W-1:0]          w_fl_idx;
    logic                      w_fl_any;
    logic                      w_victim_any;
    logic                      w_wr_ready;
    logic                      w_last_set;

    assign o_valid_out = r_valid[i_rd_set];
    assign o_dirty_out = r_dirty[i_rd_set];
    assign o_all_valid = &r_valid[i_rd_set];

    cache_way_pick #(.WAYS(WAYS)) u_victim_pick (
        .i_bits (~r_valid[i_rd_set]),
        .o_idx  (o_victim_way),
        .o_any  (w_victim_any)
    );

    cache_way_pick #(.WAYS(WAYS)) u_flush_pick (
        .i_bits (r_valid[r_set] & r_dirty[r_set]),
        .o_idx  (w_fl_idx),
        .o_any  (w_fl_any)
    );

    assign w_wr_ready   = (r_state == StIdle);
    assign w_last_set   = (r_set == SET_W'(SETS - 1));
    assign o_wr_ready   = w_wr_ready;
    assign o_flush_busy = (r_state != StIdle);
    assign o_flush_done = (r_state == StDone);
    assign o_wb_valid   = (r_state == StWb);
    assign o_wb_set     = r_wb_set;
    assign o_wb_way     = r_wb_way;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (i_flush_req) w_state_d = StScan;
            StScan: begin
                if (w_fl_any) begin
                    w_state_d = StWb;
                end else if (w_last_set) begin
                    w_state_d = StDone;
                end
            end
            StWb:   if (i_wb_ready) w_state_d = StScan;
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Set counter and latched write-back offer; the offer stays put while in WB.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_set    <= '0;
            r_wb_set <= '0;
            r_wb_way <= '0;
        end else begin
            if (r_state == StIdle && i_flush_req) begin
                r_set <= '0;
            end else if (r_state == StScan) begin
                if (w_fl_any) begin
                    r_wb_set <= r_set;
                    r_wb_way <= w_fl_idx;
                end else if (!w_last_set) begin
                    r_set <= r_set + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_wr_en && w_wr_ready) begin
                for (int i = 0; i < int'(WAYS); i++) begin
                    if (i_wr_way_mask[i]) begin
                        r_valid[i_wr_set][i] <= i_wr_valid;
                        r_dirty[i_wr_set][i] <= i_wr_dirty & i_wr_valid;
                    end
                end
            end
            // A set with no dirty line holds no dirty bits, so only valid needs clearing.
            if (r_state == StScan && !w_fl_any) begin
                r_valid[r_set] <= '0;
            end
            if (r_state == StWb && i_wb_ready) begin
                r_valid[r_wb_set][r_wb_way] <= 1'b0;
                r_dirty[r_wb_set][r_wb_way] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_state_array.sv
// Directed bench for cache_state_array: lookup, writes, clean/dirty flushes, reset in WB.
module tb_cache_state_array;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rd_set;
    logic [3:0] valid_out, dirty_out;
    logic [1:0] victim_way;
    logic       all_valid;
    logic       wr_en, wr_ready;
    logic [2:0] wr_set;
    logic [3:0] wr_way_mask;
    logic       wr_valid, wr_dirty;
    logic       flush_req, flush_busy, flush_done;
    logic       wb_valid, wb_ready;
    logic [2:0] wb_set;
    logic [1:0] wb_way;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_state_array #(.SETS(8), .WAYS(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_rd_set      (rd_set),
        .o_valid_out   (valid_out),
        .o_dirty_out   (dirty_out),
        .o_victim_way  (victim_way),
        .o_all_valid   (all_valid),
        .i_wr_en       (wr_en),
        .o_wr_ready    (wr_ready),
        .i_wr_set      (wr_set),
        .i_wr_way_mask (wr_way_mask),
        .i_wr_valid    (wr_valid),
        .i_wr_dirty    (wr_dirty),
        .i_flush_req   (flush_req),
        .o_flush_busy  (flush_busy),
        .o_flush_done  (flush_done),
        .o_wb_valid    (wb_valid),
        .i_wb_ready    (wb_ready),
        .o_wb_set      (wb_set),
        .o_wb_way      (wb_way)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int s, input logic [3:0] m, input logic v, input logic d);
        wr_en       = 1'b1;
        wr_set      = 3'(s);
        wr_way_mask = m;
        wr_valid    = v;
        wr_dirty    = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic chk_all_empty(input string tag);
        for (int s = 0; s < 8; s++) begin
            rd_set = 3'(s);
            #1;
            chk($sformatf("%s_valid_s%0d", tag, s), 32'(valid_out), 32'h0);
            chk($sformatf("%s_dirty_s%0d", tag, s), 32'(dirty_out), 32'h0);
        end
    endtask

    int         cyc;
    int         busy_cnt;
    int         done_cnt;
    int         done_at;
    int         wb_seen;
    int         n_off;
    int         stall;
    int         unstable;
    logic       prev_wb;
    logic [2:0] off_set [4];
    logic [1:0] off_way [4];

    initial begin
        reset = 1'b1; rd_set = '0; wr_en = 1'b0; wr_set = '0; wr_way_mask = '0;
        wr_valid = 1'b0; wr_dirty = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        for (int s = 0; s < 8; s++) begin
            rd_set = 3'(s);
            #1;
            chk("rst_valid", 32'(valid_out), 0);
            chk("rst_dirty", 32'(dirty_out), 0);
            chk("rst_victim", 32'(victim_way), 0);
            chk("rst_all_valid", 32'(all_valid), 0);
        end
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_busy", 32'(flush_busy), 0);
        chk("rst_done", 32'(flush_done), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_set", 32'(wb_set), 0);
        chk("rst_wb_way", 32'(wb_way), 0);

        // Writes and lookup
        rd_set = 3'd3;
        wr(3, 4'b0101, 1'b1, 1'b1);
        chk("w1_valid", 32'(valid_out), 32'h5);
        chk("w1_dirty", 32'(dirty_out), 32'h5);
        chk("w1_victim", 32'(victim_way), 1);
        chk("w1_all_valid", 32'(all_valid), 0);
        wr(3, 4'b1010, 1'b1, 1'b0);
        chk("w2_valid", 32'(valid_out), 32'hf);
        chk("w2_dirty", 32'(dirty_out), 32'h5);
        chk("w2_all_valid", 32'(all_valid), 1);
        chk("w2_victim", 32'(victim_way), 0);
        wr(3, 4'b0001, 1'b0, 1'b1);
        chk("w3_valid", 32'(valid_out), 32'he);
        chk("w3_dirty", 32'(dirty_out), 32'h4);
        chk("w3_victim", 32'(victim_way), 0);
        chk("w3_all_valid", 32'(all_valid), 0);
        rd_set = 3'd2;
        #1;
        chk("w3_other_set", 32'(valid_out), 0);

        // Clean flush: leave only clean valid lines behind
        wr(3, 4'b1111, 1'b0, 1'b0);
        wr(5, 4'b0011, 1'b1, 1'b0);
        rd_set = 3'd5;
        #1;
        chk("pre_clean_valid", 32'(valid_out), 32'h3);
        chk("pre_clean_victim", 32'(victim_way), 2);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1; wb_seen = 0; cyc = 0;
        while (flush_busy && cyc < 100) begin
            if (wb_valid) wb_seen++;
            if (flush_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            busy_cnt++;
            tick();
            cyc++;
        end
        chk("clean_busy_cycles", 32'(busy_cnt), 9);
        chk("clean_done_cycle", 32'(done_at), 8);
        chk("clean_done_count", 32'(done_cnt), 1);
        chk("clean_wb_seen", 32'(wb_seen), 0);
        chk("clean_wr_ready", 32'(wr_ready), 1);
        chk("clean_done_low", 32'(flush_done), 0);
        chk_all_empty("clean");

        // Dirty flush with a 3-cycle stall on the first offer
        wr(2, 4'b1010, 1'b1, 1'b1);
        wr(2, 4'b0100, 1'b1, 1'b0);
        wr(7, 4'b0001, 1'b1, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; n_off = 0; stall = 0; unstable = 0;
        prev_wb = 1'b0; cyc = 0;
        while (flush_busy && cyc < 100) begin
            if (wb_valid) begin
                if (!prev_wb) begin
                    if (n_off < 4) begin
                        off_set[n_off] = wb_set;
                        off_way[n_off] = wb_way;
                    end
                    n_off++;
                end else if (n_off <= 4 &&
                             (wb_set !== off_set[n_off-1] || wb_way !== off_way[n_off-1])) begin
                    unstable++;
                end
            end
            prev_wb = wb_valid;
            if (flush_done) done_cnt++;
            if (cyc == 5) begin
                chk("busy_wr_ready", 32'(wr_ready), 0);
                wr_en = 1'b1; wr_set = 3'd0; wr_way_mask = 4'hf;
                wr_valid = 1'b1; wr_dirty = 1'b0;
                flush_req = 1'b1;
            end
            wb_ready = wb_valid && (n_off > 1 || stall >= 3);
            if (wb_valid && !wb_ready) stall++;
            busy_cnt++;
            tick();
            wr_en = 1'b0;
            flush_req = 1'b0;
            cyc++;
        end
        wb_ready = 1'b0;
        chk("dirty_busy_cycles", 32'(busy_cnt), 18);
        chk("dirty_offers", 32'(n_off), 3);
        chk("dirty_off0", {off_set[0], off_way[0]}, {3'd2, 2'd1});
        chk("dirty_off1", {off_set[1], off_way[1]}, {3'd2, 2'd3});
        chk("dirty_off2", {off_set[2], off_way[2]}, {3'd7, 2'd0});
        chk("dirty_stable", 32'(unstable), 0);
        chk("dirty_done_count", 32'(done_cnt), 1);
        tick();
        chk("no_second_flush", 32'(flush_busy), 0);
        chk_all_empty("dirty");

        // Write and flush_req together: write lands first, then is swept
        wr_en = 1'b1; wr_set = 3'd4; wr_way_mask = 4'b0001; wr_valid = 1'b1; wr_dirty = 1'b1;
        flush_req = 1'b1;
        tick();
        wr_en = 1'b0;
        flush_req = 1'b0;
        rd_set = 3'd4;
        #1;
        chk("coinc_valid", 32'(valid_out), 32'h1);
        chk("coinc_dirty", 32'(dirty_out), 32'h1);
        chk("coinc_busy", 32'(flush_busy), 1);
        busy_cnt = 0; n_off = 0; prev_wb = 1'b0; cyc = 0;
        wb_ready = 1'b1;
        while (flush_busy && cyc < 100) begin
            if (wb_valid && !prev_wb) begin
                if (n_off < 4) begin
                    off_set[n_off] = wb_set;
                    off_way[n_off] = wb_way;
                end
                n_off++;
            end
            prev_wb = wb_valid;
            busy_cnt++;
            tick();
            cyc++;
        end
        wb_ready = 1'b0;
        chk("coinc_busy_cycles", 32'(busy_cnt), 11);
        chk("coinc_offers", 32'(n_off), 1);
        chk("coinc_off0", {off_set[0], off_way[0]}, {3'd4, 2'd0});
        chk_all_empty("coinc");

        // Reset while stalled in WB
        wr(6, 4'b1111, 1'b1, 1'b0);
        wr(1, 4'b0100, 1'b1, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        cyc = 0;
        while (!wb_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("rwb_reached_wb", 32'(wb_valid), 1);
        chk("rwb_offer", {wb_set, wb_way}, {3'd1, 2'd2});
        reset = 1'b1;
        tick();
        chk("rwb_wb_valid", 32'(wb_valid), 0);
        chk("rwb_busy", 32'(flush_busy), 0);
        chk("rwb_done", 32'(flush_done), 0);
        chk("rwb_wr_ready", 32'(wr_ready), 1);
        chk("rwb_wb_set", 32'(wb_set), 0);
        chk("rwb_wb_way", 32'(wb_way), 0);
        chk_all_empty("rwb");
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush_done || flush_busy) done_cnt++;
        end
        chk("rwb_no_done", 32'(done_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
